dc_ipu_filter_phase_gen: RTL and testbench

DC_IPU_FILTER_PHASE_GEN -- requirements
Module: dc_ipu_filter_phase_gen

---
 rtl/dc_ipu_filter_phase_gen.sv | 112 +++++++++++
 tb/tb_dc_ipu_filter_phase_gen.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dc_ipu_filter_phase_gen.sv
// rtl/dc_ipu_filter_phase_gen.sv - per-pixel source phase, fractional weight and clamped 4-tap indices
// One output pixel per handshake; source position advances by step in fixed point.
module dc_ipu_filter_phase_gen #(
  parameter int WEIGHT_WIDTH       = 12,
  parameter int WEIGHT_FRACT_WIDTH = 8,
  parameter int IDX_WIDTH          = 12
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     start,
  input  logic [IDX_WIDTH+WEIGHT_FRACT_WIDTH-1:0]  step,
  input  logic signed [IDX_WIDTH+WEIGHT_FRACT_WIDTH:0] init_phase,
  input  logic [IDX_WIDTH-1:0]                     out_len,
  input  logic [IDX_WIDTH-1:0]                     src_len,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [WEIGHT_WIDTH-1:0]                  alpha,
  output logic [IDX_WIDTH-1:0]                     tap_idx [0:3],
  output logic                                     last,
  output logic                                     busy,
  output logic                                     done
);

  localparam int ACC_W = IDX_WIDTH + WEIGHT_FRACT_WIDTH + 1;
  localparam int EXT_W = ACC_W + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                                 state;
  logic signed [ACC_W-1:0]                acc;
  logic [IDX_WIDTH+WEIGHT_FRACT_WIDTH-1:0] step_r;
  logic [IDX_WIDTH-1:0]                   out_len_r;
  logic [IDX_WIDTH-1:0]                   src_len_r;
  logic [IDX_WIDTH-1:0]                   cnt;

  logic                                   running;
  logic                                   last_pix;
  logic signed [ACC_W-1:0]                base;
  logic signed [EXT_W-1:0]                base_ext;
  logic signed [EXT_W-1:0]                max_idx;
  logic signed [EXT_W-1:0]                t;

  assign running  = (state == RUN);
  assign last_pix = (cnt == out_len_r - 1'b1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      step_r    <= '0;
      out_len_r <= '0;
      src_len_r <= '0;
      cnt       <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (out_len != '0) begin
              state     <= RUN;
              acc       <= init_phase;
              step_r    <= step;
              out_len_r <= out_len;
              src_len_r <= src_len;
              cnt       <= '0;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (out_ready) begin
            acc <= acc + $signed({1'b0, step_r});
            cnt <= cnt + 1'b1;
            if (last_pix) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Taps are clamped one bit wider than the accumulator so base-1 and base+2 never wrap.
  assign base     = acc >>> WEIGHT_FRACT_WIDTH;
  assign base_ext = {base[ACC_W-1], base};
  assign max_idx  = $signed({{(EXT_W-IDX_WIDTH){1'b0}}, src_len_r}) - EXT_W'(1);

  always_comb begin
    t = '0;
    for (int k = 0; k < 4; k++) begin
      t = base_ext + EXT_W'(k) - EXT_W'(1);
      if (!running)
        tap_idx[k] = '0;
      else if (t < 0)
        tap_idx[k] = '0;
      else if (t > max_idx)
        tap_idx[k] = src_len_r - 1'b1;
      else
        tap_idx[k] = t[IDX_WIDTH-1:0];
    end
  end

  assign out_valid = running;
  assign busy      = running;
  assign last      = running && last_pix;
  assign alpha     = running ? WEIGHT_WIDTH'(acc[WEIGHT_FRACT_WIDTH-1:0]) : '0;

endmodule

// File: tb/tb_dc_ipu_filter_phase_gen.sv
// tb/tb_dc_ipu_filter_phase_gen.sv - directed table, corner sequences and randomized lines vs an arithmetic model
module tb_dc_ipu_filter_phase_gen;

  localparam int WW  = 12;
  localparam int WFW = 8;
  localparam int IW  = 12;
  localparam int SW  = IW + WFW;
  localparam int AW  = IW + WFW + 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [SW-1:0]        step;
  logic signed [AW-1:0] init_phase;
  logic [IW-1:0]        out_len;
  logic [IW-1:0]        src_len;
  logic                 out_valid;
  logic                 out_ready;
  logic [WW-1:0]        alpha;
  logic [IW-1:0]        tap_idx [0:3];
  logic                 last;
  logic                 busy;
  logic                 done;

  always #5 clk = ~clk;

  dc_ipu_filter_phase_gen #(
    .WEIGHT_WIDTH(WW), .WEIGHT_FRACT_WIDTH(WFW), .IDX_WIDTH(IW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .step(step), .init_phase(init_phase),
    .out_len(out_len), .src_len(src_len), .out_valid(out_valid), .out_ready(out_ready),
    .alpha(alpha), .tap_idx(tap_idx), .last(last), .busy(busy), .done(done)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
  endtask

  function automatic longint pack4(input longint a, input longint b, input longint c, input longint d);
    return (a << 36) | (b << 24) | (c << 12) | d;
  endfunction

  function automatic longint dut_taps();
    return pack4(longint'(tap_idx[0]), longint'(tap_idx[1]), longint'(tap_idx[2]), longint'(tap_idx[3]));
  endfunction

  // Reference: source position is init + i*step; integer part floors, fraction is the remainder.
  task automatic model(input longint init, input longint st, input longint src, input longint i,
                       output longint a, output longint tp);
    longint pos, b, t;
    longint tv [4];
    pos = init + i * st;
    b   = pos >>> WFW;
    a   = pos - b * (64'sd1 << WFW);
    for (int k = 0; k < 4; k++) begin
      t = b + k - 1;
      if (t < 0) t = 0;
      if (t > src - 1) t = src - 1;
      tv[k] = t;
    end
    tp = pack4(tv[0], tv[1], tv[2], tv[3]);
  endtask

  task automatic scramble_cfg();
    step       = SW'($urandom);
    init_phase = AW'($urandom);
    out_len    = IW'($urandom);
    src_len    = IW'($urandom);
  endtask

  // Called on a negedge with the DUT idle; returns on the negedge where pixel 0 is shown.
  task automatic begin_line(input longint st, input longint init, input longint olen, input longint src);
    start      = 1'b1;
    step       = SW'(st);
    init_phase = AW'(init);
    out_len    = IW'(olen);
    src_len    = IW'(src);
    @(negedge clk);
    start = 1'b0;
    scramble_cfg();
  endtask

  task automatic run_line(input longint st, input longint init, input longint olen, input longint src,
                          input int max_stall, input int stall_pix, input int stall_n, input bit disturb);
    longint ea, et;
    int nst;
    begin_line(st, init, olen, src);
    for (int i = 0; i < olen; i++) begin
      nst = 0;
      if (max_stall > 0 && $urandom_range(0, 2) == 0) nst = $urandom_range(1, max_stall);
      if (i == stall_pix) nst = stall_n;
      model(init, st, src, i, ea, et);
      for (int s = 0; s <= nst; s++) begin
        out_ready = (s == nst);
        start     = disturb && ((i == 1 && s == 0) || (i == olen - 1 && s == nst));
        if (start) begin
          out_len = IW'($urandom_range(1, 9));
          step    = SW'($urandom);
        end
        chk($sformatf("valid[%0d]", i), out_valid, 1);
        chk($sformatf("busy[%0d]", i), busy, 1);
        chk($sformatf("alpha[%0d]", i), alpha, ea);
        chk($sformatf("taps[%0d]", i), dut_taps(), et);
        chk($sformatf("last[%0d]", i), last, (i == olen - 1) ? 1 : 0);
        chk($sformatf("done_mid[%0d]", i), done, 0);
        @(negedge clk);
      end
    end
    start = 1'b0;
    chk("end_valid", out_valid, 0);
    chk("end_busy", busy, 0);
    chk("end_last", last, 0);
    chk("end_done", done, 1);
    @(negedge clk);
    chk("post_done", done, 0);
    chk("post_valid", out_valid, 0);
  endtask

  typedef struct {
    longint st;
    longint init;
    longint olen;
    longint src;
    int     pix;
    longint alpha;
    longint taps;
    bit     last;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input longint st, input longint init, input longint olen, input longint src,
                     input int pix, input longint a, input longint tp, input bit l);
    vec_t v;
    v = '{st, init, olen, src, pix, a, tp, l};
    tbl.push_back(v);
  endtask

  initial begin
    int guard;
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    step = '0; init_phase = '0; out_len = '0; src_len = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_last", last, 0);
    chk("rst_alpha", alpha, 0);
    chk("rst_taps", dut_taps(), 0);
    reset = 1'b0;
    @(negedge clk);

    add('h100, 0, 4, 4, 0, 0, pack4(0, 0, 1, 2), 0);
    add('h100, 0, 4, 4, 1, 0, pack4(0, 1, 2, 3), 0);
    add('h100, 0, 4, 4, 2, 0, pack4(1, 2, 3, 3), 0);
    add('h100, 0, 4, 4, 3, 0, pack4(2, 3, 3, 3), 1);
    add('h180, 0, 3, 8, 0, 'h00, pack4(0, 0, 1, 2), 0);
    add('h180, 0, 3, 8, 1, 'h80, pack4(0, 1, 2, 3), 0);
    add('h180, 0, 3, 8, 2, 'h00, pack4(2, 3, 4, 5), 1);
    add('h080, -'h40, 4, 4, 0, 'hC0, pack4(0, 0, 0, 1), 0);
    add('h080, -'h40, 4, 4, 1, 'h40, pack4(0, 0, 1, 2), 0);
    add('h100, 'h500, 2, 4, 0, 0, pack4(3, 3, 3, 3), 0);
    add('h100, 0, 1, 1, 0, 0, pack4(0, 0, 0, 0), 1);

    foreach (tbl[n]) begin
      begin_line(tbl[n].st, tbl[n].init, tbl[n].olen, tbl[n].src);
      out_ready = 1'b1;
      for (int p = 0; p < tbl[n].pix; p++) @(negedge clk);
      chk($sformatf("tbl%0d_valid", n), out_valid, 1);
      chk($sformatf("tbl%0d_alpha", n), alpha, tbl[n].alpha);
      chk($sformatf("tbl%0d_taps", n), dut_taps(), tbl[n].taps);
      chk($sformatf("tbl%0d_last", n), last, tbl[n].last);
      guard = 0;
      while (out_valid && guard < 64) begin
        @(negedge clk);
        guard++;
      end
      chk($sformatf("tbl%0d_drain", n), out_valid, 0);
      chk($sformatf("tbl%0d_done", n), done, 1);
      @(negedge clk);
    end

    // Zero-length line: done pulse only.
    start = 1'b1; out_len = '0; src_len = IW'(4); step = SW'('h100); init_phase = '0;
    @(negedge clk);
    start = 1'b0;
    chk("zl_done", done, 1);
    chk("zl_valid", out_valid, 0);
    chk("zl_busy", busy, 0);
    @(negedge clk);
    chk("zl_done_clr", done, 0);
    chk("zl_valid2", out_valid, 0);

    // Backpressure: the stalled run must match the unstalled one pixel for pixel.
    run_line('h180, 0, 3, 8, 0, -1, 0, 1'b0);
    run_line('h180, 0, 3, 8, 0, 1, 3, 1'b0);
    run_line('h100, 0, 4, 4, 0, 1, 3, 1'b1);

    // Reset mid-line on pixel 2 of 4, then restart.
    begin_line('h100, 'h80, 4, 6);
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mr_alpha_p2", alpha, 'h80);
    chk("mr_taps_p2", dut_taps(), pack4(1, 2, 3, 4));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mr_valid", out_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_last", last, 0);
    chk("mr_alpha", alpha, 0);
    chk("mr_taps", dut_taps(), 0);
    @(negedge clk);
    chk("mr_done2", done, 0);
    run_line('h100, 'h80, 4, 6, 0, -1, 0, 1'b0);

    for (int r = 0; r < 40; r++) begin
      run_line(longint'($urandom_range(1, 'h400)),
               longint'($urandom_range(0, 69632)) - 4096,
               longint'($urandom_range(1, 16)),
               longint'($urandom_range(1, 24)),
               2, -1, 0, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
